// File: rtl/mult_div_pkg.sv
// Shared function codes for the EX-stage multiply/divide instructions,
// plus small decode helpers used when a request is latched.
package mult_div_pkg;

   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1a;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_kind_t;

   // True for any of the four codes this unit serves.
   function automatic logic is_mult_div_funct(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
             (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
   endfunction

   // True for the two's-complement variants.
   function automatic logic is_signed_funct(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_DIV);
   endfunction

endpackage

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit. Works on operand magnitudes with a
// shared 64-bit working register: radix-2 shift-add for multiply, radix-2
// restoring for divide, one iteration per cycle, sign fix applied at the end.
module mult_div
   import mult_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  funct,
   input  logic [31:0] operand_1,
   input  logic [31:0] operand_2,
   input  logic        stall_in,
   input  logic        flush,
   output logic        done_flag,
   output logic [63:0] result
);

   localparam int ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_reg;
   logic [5:0]  count_reg;
   logic [63:0] acc_reg;       // multiply: {partial product, multiplier}; divide: {remainder, quotient}
   logic [31:0] mag2_reg;      // multiplicand magnitude or divisor magnitude
   logic [31:0] op1_raw_reg;   // unmodified operand_1, needed for the divide-by-zero result
   op_kind_t    op_reg;
   logic        neg_q_reg;     // product or quotient sign
   logic        neg_r_reg;     // remainder sign
   logic        div_zero_reg;

   logic        start_ok;
   logic        signed_op;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [32:0] add_sum;
   logic [32:0] trial;
   logic [63:0] step_acc;
   logic [31:0] hi_fix;
   logic [31:0] lo_fix;
   logic [63:0] final_result;

   // Request decode and operand magnitudes for the latch in IDLE.
   always_comb begin
      start_ok  = start && is_mult_div_funct(funct);
      signed_op = is_signed_funct(funct);
      mag1      = (signed_op && operand_1[31]) ? (32'd0 - operand_1) : operand_1;
      mag2      = (signed_op && operand_2[31]) ? (32'd0 - operand_2) : operand_2;
   end

   // One radix-2 iteration of the current operation, and the signed result
   // that the last iteration would produce.
   always_comb begin
      add_sum = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, mag2_reg} : 33'd0);
      trial   = acc_reg[63:31] - {1'b0, mag2_reg};
      if (op_reg == OP_MUL) begin
         step_acc = {add_sum, acc_reg[31:1]};
      end else if (trial[32]) begin
         step_acc = {acc_reg[62:0], 1'b0};
      end else begin
         step_acc = {trial[31:0], acc_reg[30:0], 1'b1};
      end
      hi_fix = neg_r_reg ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
      lo_fix = neg_q_reg ? (32'd0 - step_acc[31:0])  : step_acc[31:0];
      if (op_reg == OP_MUL) begin
         final_result = neg_q_reg ? (64'd0 - step_acc) : step_acc;
      end else if (div_zero_reg) begin
         final_result = {op1_raw_reg, 32'hFFFF_FFFF};
      end else begin
         final_result = {hi_fix, lo_fix};
      end
   end

   // Control FSM with registered outputs; reset outranks flush, flush outranks everything else.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_reg    <= ST_IDLE;
         count_reg    <= 6'd0;
         done_flag    <= 1'b0;
         result       <= 64'd0;
         acc_reg      <= 64'd0;
         mag2_reg     <= 32'd0;
         op1_raw_reg  <= 32'd0;
         op_reg       <= OP_MUL;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               done_flag <= 1'b0;
               if (start_ok) begin
                  state_reg    <= ST_BUSY;
                  count_reg    <= 6'd0;
                  acc_reg      <= {32'd0, mag1};
                  mag2_reg     <= mag2;
                  op1_raw_reg  <= operand_1;
                  op_reg       <= ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU)) ? OP_DIV : OP_MUL;
                  neg_q_reg    <= signed_op && (operand_1[31] ^ operand_2[31]);
                  neg_r_reg    <= signed_op && operand_1[31];
                  div_zero_reg <= ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU)) &&
                                  (operand_2 == 32'd0);
               end
            end
            ST_BUSY: begin
               acc_reg   <= step_acc;
               count_reg <= count_reg + 6'd1;
               if (count_reg == 6'(ITER - 1)) begin
                  state_reg <= ST_DONE;
                  result    <= final_result;
                  done_flag <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!stall_in) begin
                  state_reg <= ST_IDLE;
                  done_flag <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               done_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed cases, randomized operations
// against an arithmetic reference model, stall/flush/reset scenarios.
module tb_mult_div;
   import mult_div_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  funct;
   logic [31:0] operand_1;
   logic [31:0] operand_2;
   logic        stall_in;
   logic        flush;
   logic        done_flag;
   logic [63:0] result;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   mult_div dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .funct     (funct),
      .operand_1 (operand_1),
      .operand_2 (operand_2),
      .stall_in  (stall_in),
      .flush     (flush),
      .done_flag (done_flag),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // HI:LO as the ISA defines it, computed with plain integer arithmetic.
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb, q, r;
      logic [63:0] qv, rv;
      ia = a; ib = b;
      sa = ia; sb = ib;
      case (f)
         FUNCT_MULT:  return 64'(sa * sb);
         FUNCT_MULTU: return {32'd0, a} * {32'd0, b};
         FUNCT_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb; r = sa % sb;
            qv = q; rv = r;
            return {rv[31:0], qv[31:0]};
         end
         FUNCT_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Issue one operation, drop start after the latch, scramble the operands
   // during BUSY, and check latency, result and the following IDLE cycle.
   task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [63:0] exp;
      int n;
      exp = model(f, a, b);
      @(negedge clk);
      start = 1'b1; funct = f; operand_1 = a; operand_2 = b;
      @(posedge clk); n = 1;
      @(negedge clk);
      start = 1'b0; operand_1 = $urandom; operand_2 = $urandom;
      while (!done_flag && n < 100) begin
         @(posedge clk); n++;
         @(negedge clk);
      end
      check({tag, " latency"}, 64'(n), 64'd33);
      check({tag, " result"}, result, exp);
      @(posedge clk); @(negedge clk);
      check({tag, " done drop"}, {63'd0, done_flag}, 64'd0);
      $display("op %s funct=%h a=%h b=%h -> result=%h (expected %h) latency=%0d",
               tag, f, a, b, result, exp, n);
   endtask

   initial begin
      logic [5:0]  codes [4];
      logic [5:0]  rf;
      logic [31:0] ra, rb;
      logic [63:0] held;
      int          n;
      codes[0] = FUNCT_MULT; codes[1] = FUNCT_MULTU; codes[2] = FUNCT_DIV; codes[3] = FUNCT_DIVU;

      rst = 1'b1; start = 1'b0; funct = 6'd0; operand_1 = 32'd0; operand_2 = 32'd0;
      stall_in = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset done", {63'd0, done_flag}, 64'd0);
      check("reset result", result, 64'd0);
      rst = 1'b0;

      // Directed cases from the arithmetic corner list.
      do_op(FUNCT_MULT,  32'hFFFF_FFFD, 32'd5,         "mult -3x5");
      check("mult -3x5 const", result, 64'hFFFF_FFFF_FFFF_FFF1);
      do_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
      check("multu max const", result, 64'hFFFF_FFFE_0000_0001);
      do_op(FUNCT_DIVU,  32'd100,       32'd7,         "divu 100/7");
      check("divu 100/7 const", result, {32'd2, 32'd14});
      do_op(FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         "div -7/2");
      check("div -7/2 const", result, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
      check("div min/-1 const", result, 64'h0000_0000_8000_0000);
      do_op(FUNCT_DIVU,  32'h0000_1234, 32'd0,         "divu by 0");
      check("divu by 0 const", result, 64'h0000_1234_FFFF_FFFF);
      do_op(FUNCT_DIV,   32'hFFFF_FFFB, 32'd0,         "div -5/0");
      check("div -5/0 const", result, 64'hFFFF_FFFB_FFFF_FFFF);

      // Randomized operations against the reference model.
      for (int i = 0; i < 10; i++) begin
         rf = codes[$urandom_range(3, 0)];
         ra = $urandom;
         rb = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(15, 0)) : $urandom;
         if (i % 3 == 1) ra = 32'($urandom_range(200, 0));
         do_op(rf, ra, rb, $sformatf("rand%0d", i));
      end

      // Unknown funct with start high: the block must stay idle.
      @(negedge clk);
      start = 1'b1; funct = 6'h20; operand_1 = 32'd3; operand_2 = 32'd4;
      held = result;
      n = 0;
      repeat (40) begin
         @(posedge clk); @(negedge clk);
         if (done_flag) n++;
      end
      start = 1'b0;
      check("bad funct no done", 64'(n), 64'd0);
      check("bad funct result kept", result, held);
      $display("op bad-funct done_cycles=%0d", n);

      // Stall in DONE, then a level-held start for a second operation.
      @(negedge clk);
      start = 1'b1; funct = FUNCT_DIVU; operand_1 = 32'd100; operand_2 = 32'd7;
      @(posedge clk); n = 1;
      @(negedge clk);
      funct = FUNCT_MULTU; operand_1 = 32'd2; operand_2 = 32'd3; stall_in = 1'b1;
      while (n < 33) begin @(posedge clk); n++; @(negedge clk); end
      check("stall first done", {63'd0, done_flag}, 64'd1);
      check("stall first result", result, {32'd2, 32'd14});
      while (n < 36) begin
         @(posedge clk); n++; @(negedge clk);
         check($sformatf("stall hold done c%0d", n), {63'd0, done_flag}, 64'd1);
         check($sformatf("stall hold result c%0d", n), result, {32'd2, 32'd14});
      end
      stall_in = 1'b0;
      @(posedge clk); n++; @(negedge clk);
      check("stall release done", {63'd0, done_flag}, 64'd0);
      @(posedge clk); n++; @(negedge clk);
      start = 1'b0;
      while (!done_flag && n < 120) begin @(posedge clk); n++; @(negedge clk); end
      check("restart cycle", 64'(n), 64'd70);
      check("restart result", result, 64'd6);
      $display("op stall+restart second_done_cycle=%0d result=%h", n, result);
      @(posedge clk); @(negedge clk);

      // Flush mid-BUSY abandons the operation.
      start = 1'b1; funct = FUNCT_DIVU; operand_1 = 32'd50; operand_2 = 32'd5;
      @(posedge clk); n = 1;
      @(negedge clk);
      start = 1'b0;
      while (n < 10) begin @(posedge clk); n++; @(negedge clk); end
      flush = 1'b1;
      @(posedge clk); n++; @(negedge clk);
      flush = 1'b0;
      check("flush result", result, 64'd0);
      held = 64'd0;
      repeat (40) begin
         @(posedge clk); @(negedge clk);
         if (done_flag) held = held + 64'd1;
      end
      check("flush no done", held, 64'd0);
      $display("op flush done_cycles=%0d", held);
      do_op(FUNCT_DIVU, 32'd9, 32'd3, "divu 9/3 after flush");
      check("after flush const", result, {32'd0, 32'd3});

      // Reset mid-BUSY.
      @(negedge clk);
      start = 1'b1; funct = FUNCT_MULT; operand_1 = 32'd7; operand_2 = 32'd9;
      @(posedge clk); n = 1;
      @(negedge clk);
      start = 1'b0;
      while (n < 20) begin @(posedge clk); n++; @(negedge clk); end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      check("rst done", {63'd0, done_flag}, 64'd0);
      check("rst result", result, 64'd0);
      $display("op reset-midbusy done=%0d result=%h", done_flag, result);
      do_op(FUNCT_DIVU, 32'd9, 32'd3, "divu 9/3 after rst");
      check("after rst const", result, {32'd0, 32'd3});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mult_div.md
# mult_div

Multi-cycle multiply/divide unit that serves MULT, MULTU, DIV and DIVU for the EX stage. EX issues a request while one of these instructions occupies it and stalls until this block raises `done_flag`. The block then returns the 64-bit HI:LO result that EX writes into HI/LO. It sits beside EX in the core, and its outputs drive EX's `mult_div_done_flag` and `mult_div_result`.

## Interface
Parameters:
- `ITER`, 32, number of iteration cycles in BUSY; fixed at 32 for 32-bit operands.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request; EX holds it high while a valid MULT/MULTU/DIV/DIVU is in EX.
- `funct`  in  6  function code: MULT 6'h18, MULTU 6'h19, DIV 6'h1a, DIVU 6'h1b.
- `operand_1`  in  32  multiplicand / dividend (rs).
- `operand_2`  in  32  multiplier / divisor (rt).
- `stall_in`  in  1  pipeline held by another stage; EX does not advance this cycle.
- `flush`  in  1  exception flush; abandons any operation.
- `done_flag`  out  1  result valid; drives EX `mult_div_done_flag`.
- `result`  out  64  {HI, LO}; drives EX `mult_div_result`.

## Operation
- States: IDLE, BUSY, DONE. Reset and flush force IDLE, `done_flag`=0, `result`=0, iteration counter=0.
- IDLE: if `start`=1 and `funct` is one of the four codes, latch the following and go to BUSY with counter=0:
  - the operation;
  - the operand magnitudes (signed ops take the absolute value; unsigned ops use the raw value);
  - the result signs: product or quotient sign = op1[31]^op2[31]; remainder sign = op1[31]. Both are forced to 0 for unsigned ops.
  - Any other `funct` leaves the block in IDLE.
- BUSY: one iteration per cycle, with a 6-bit counter.
  - Multiply is radix-2 shift-add over a 64-bit accumulator.
  - Divide is radix-2 restoring; the quotient fills the low half and the remainder fills the high half.
  - Inputs are ignored after the latch.
  - On the edge that completes iteration 31: apply the sign fix and load `result`, go to DONE.
  - Sign fix: multiply negates the 64-bit product if its sign is set. Divide negates LO if the quotient sign is set, and negates HI if the remainder sign is set.
- DONE: `done_flag`=1.
  - If `stall_in`=1, stay in DONE with `result` held.
  - Otherwise go to IDLE on the next edge.
  - `result` keeps its last value in IDLE (not cleared).
- Divide by zero (op2==0, DIV or DIVU): `result` = {operand_1 as latched, 32'hFFFFFFFF}, with no sign fix applied. Latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no exception.
- `flush` has priority over every transition. `rst` has priority over `flush`.
- `start` is level-sensitive. After DONE→IDLE, a still-high `start` means a new instruction is in EX, and the block begins a new operation.

## Timing
- Latency: `start` sampled in IDLE at cycle 0; BUSY in cycles 1–32; `done_flag`=1 and `result` valid in cycle 33.
- `done_flag` is a registered output and is high only in DONE.
- Back-to-back requests: the earliest restart is IDLE in cycle 34, giving DONE again in cycle 67.
- Operand changes during BUSY have no effect.
- Reset mid-BUSY: IDLE on the next edge, and a high `start` then begins a fresh operation.

## Structure
- Funct codes come from the shared funct definitions already used by EX.
- State encoding and `ITER` are localparams in this module.
- A single module with no sub-modules. Multiply and divide share the 64-bit working register and the counter.

## Test plan
- MULT op1=0xFFFFFFFD (−3), op2=5 → cycle 33: done=1, result=0xFFFFFFFF_FFFFFFF1; cycle 34: done=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE_00000001. DIVU 100/7 → HI=2, LO=14.
- DIV −7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIV 0x80000000/−1 → HI=0, LO=0x80000000.
- DIVU 0x1234/0 → HI=0x00001234, LO=0xFFFFFFFF. DIV −5/0 → HI=0xFFFFFFFB, LO=0xFFFFFFFF.
- `stall_in`=1 in cycles 33–35 → done stays 1 with result stable through cycle 35, then 0 in cycle 37. Keep `start` high with a new MULTU 2×3 → second done with result=6.
- `flush` at cycle 10 → IDLE and done never rises. `rst` at cycle 20 → all outputs 0 next cycle. After each, a new DIVU 9/3 → LO=3, HI=0 at 33 cycles.
